// File: rtl/pmem_responder_if.sv
// rtl/pmem_responder_if.sv - pmem request/response bus between the cache and the responder
interface pmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - line-granular pmem responder with programmable latency and recovery window
// Optional per-transaction latency jitter: PMEM_RESPONDER_JITTER_EN
module pmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic            clk,
  input  logic            rst,
  pmem_responder_if.slave bus,
  output logic            proto_err,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count
);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int INDEX_BITS  = $clog2(DEPTH_LINES);
  localparam int IDX_TOP     = OFFSET_BITS + INDEX_BITS;
  localparam logic [8:0] LAT_M1 = 9'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RECOVER} state_t;

  state_t                  state_q, state_d;
  logic [8:0]              cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic                    is_write_q, is_write_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    resp_q, resp_d;
  logic                    proto_err_q, proto_err_d;
  logic [15:0]             rd_count_q, rd_count_d;
  logic [15:0]             wr_count_q, wr_count_d;
  logic                    store_we;
  logic                    req;
  logic [8:0]              jitter;
  logic                    unused_addr_bits;
  logic [LINE_WIDTH-1:0]   store [DEPTH_LINES];

  assign req = bus.pmem_read | bus.pmem_write;
  // Offset bits and index bits above the store depth never select a line.
  assign unused_addr_bits = ^{bus.pmem_address[ADDR_WIDTH-1:IDX_TOP],
                              bus.pmem_address[OFFSET_BITS-1:0]};

`ifdef PMEM_RESPONDER_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign jitter = {7'd0, lfsr_q[1:0]};
`else
  assign jitter = 9'd0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    index_d     = index_q;
    is_write_d  = is_write_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = 1'b0;
    proto_err_d = proto_err_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    store_we    = 1'b0;
`ifdef PMEM_RESPONDER_JITTER_EN
    lfsr_d      = lfsr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          index_d    = bus.pmem_address[OFFSET_BITS +: INDEX_BITS];
          is_write_d = bus.pmem_write;
          wdata_d    = bus.pmem_wdata;
          cnt_d      = LAT_M1 + jitter;
          // A read and write together is a protocol violation; the write wins.
          if (bus.pmem_write) wr_count_d = wr_count_q + 16'd1;
          else                rd_count_d = rd_count_q + 16'd1;
          if (bus.pmem_read && bus.pmem_write) proto_err_d = 1'b1;
`ifdef PMEM_RESPONDER_JITTER_EN
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 9'd0) begin
          store_we = is_write_q;
          if (!is_write_q) rdata_d = store[index_q];
          resp_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      RESP:    state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      index_q     <= '0;
      is_write_q  <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 1'b0;
      proto_err_q <= 1'b0;
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
`ifdef PMEM_RESPONDER_JITTER_EN
      lfsr_q      <= 8'hA5;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      is_write_q  <= is_write_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      proto_err_q <= proto_err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
`ifdef PMEM_RESPONDER_JITTER_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  // Store has no reset; an aborted write never reaches here because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (store_we) store[index_q] <= wdata_q;
  end

  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = resp_q;
  assign proto_err      = proto_err_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;
endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - self-checking bench for pmem_responder (optionally PMEM_RESPONDER_JITTER_EN)
module tb_pmem_responder;
  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int DL  = 64;
  localparam int LAT = 4;

  localparam logic [LW-1:0] L_DB = {16'hDEAD, {14{16'h0123}}, 16'hBEEF};
  localparam logic [LW-1:0] L_A  = {8{32'hAAAA_0001}};
  localparam logic [LW-1:0] L_B  = {8{32'hBBBB_0002}};
  localparam logic [LW-1:0] L_55 = {32{8'h55}};
  localparam logic [LW-1:0] L_X1 = {8{32'h1234_5678}};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        proto_err;
  logic [15:0] rd_count, wr_count;

  always #5 clk = ~clk;

  pmem_responder_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH_LINES(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Transaction-level model: absolute edge numbers decide when things happen.
  int              cyc = 0, next_ok = 0, pend_at = -1, pend_idx = 0, mj = 0;
  bit              pend_wr = 0;
  logic [LW-1:0]   pend_data = '0;
  logic [LW-1:0]   m_store [DL];
  bit              m_valid [DL];
  logic [LW-1:0]   m_rdata = '0;
  bit              m_rdata_ok = 1;
  bit              m_resp = 0, m_perr = 0;
  logic [15:0]     m_rd = 0, m_wr = 0;
  logic [7:0]      m_lfsr = 8'hA5;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; next_ok = 0; pend_at = -1;
      m_resp = 0; m_rdata = '0; m_rdata_ok = 1; m_perr = 0;
      m_rd = 0; m_wr = 0; m_lfsr = 8'hA5;
    end else begin
      cyc++;
      m_resp = 0;
      if (cyc == pend_at) begin
        if (pend_wr) begin
          m_store[pend_idx] = pend_data;
          m_valid[pend_idx] = 1;
        end else begin
          m_rdata    = m_store[pend_idx];
          m_rdata_ok = m_valid[pend_idx];
        end
        m_resp = 1;
      end
      if (cyc >= next_ok && (bus.pmem_read || bus.pmem_write)) begin
        mj = 0;
`ifdef PMEM_RESPONDER_JITTER_EN
        mj = int'(m_lfsr[1:0]);
        m_lfsr = lfsr_step(m_lfsr);
`endif
        pend_at   = cyc + LAT + mj;
        next_ok   = pend_at + 3;
        pend_wr   = bus.pmem_write;
        pend_idx  = int'((bus.pmem_address >> 5) % DL);
        pend_data = bus.pmem_wdata;
        if (bus.pmem_write) m_wr++; else m_rd++;
        if (bus.pmem_read && bus.pmem_write) m_perr = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("resp", LW'(bus.pmem_resp), LW'(m_resp));
    check("proto_err", LW'(proto_err), LW'(m_perr));
    check("rd_count", LW'(rd_count), LW'(m_rd));
    check("wr_count", LW'(wr_count), LW'(m_wr));
    if (m_rdata_ok) check("rdata", bus.pmem_rdata, m_rdata);
  end

  task automatic do_req(input logic [AW-1:0] addr, input logic rd, input logic wr,
                        input logic [LW-1:0] data, output int lat);
    bus.pmem_address = addr;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_wdata   = data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.pmem_resp && lat < 300);
    if (!bus.pmem_resp) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got no pmem_resp expected one within 300 cycles");
    end
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    int lat;
    int resp_n;
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_resp", LW'(bus.pmem_resp), '0);
    check("rst_rdata", bus.pmem_rdata, '0);
    check("rst_perr", LW'(proto_err), '0);
    check("rst_rd", LW'(rd_count), '0);
    check("rst_wr", LW'(wr_count), '0);

    do_req(32'h0000_0040, 1'b0, 1'b1, L_DB, lat);
`ifndef PMEM_RESPONDER_JITTER_EN
    check("lat_wr", LW'(lat), LW'(5));
`endif
    do_req(32'h0000_0040, 1'b1, 1'b0, '0, lat);
`ifndef PMEM_RESPONDER_JITTER_EN
    check("lat_rd", LW'(lat), LW'(5));
`endif
    check("raw_data", bus.pmem_rdata, L_DB);
    check("raw_wr", LW'(wr_count), LW'(1));
    check("raw_rd", LW'(rd_count), LW'(1));

    do_req(32'h0000_0000, 1'b0, 1'b1, L_A, lat);
    do_req(32'h0000_1000, 1'b0, 1'b1, L_B, lat);
    do_req(32'h0000_0000, 1'b1, 1'b0, '0, lat);
    check("alias_0", bus.pmem_rdata, L_B);
    do_req(32'h0000_001F, 1'b1, 1'b0, '0, lat);
    check("alias_1f", bus.pmem_rdata, L_B);

    do_req(32'h0000_0080, 1'b1, 1'b1, L_55, lat);
    check("both_perr", LW'(proto_err), LW'(1));
    check("both_wr", LW'(wr_count), LW'(4));
    check("both_rd", LW'(rd_count), LW'(3));
    do_req(32'h0000_0080, 1'b1, 1'b0, '0, lat);
    check("both_data", bus.pmem_rdata, L_55);

    bus.pmem_address = 32'h0000_0040;
    bus.pmem_read    = 1'b1;
    resp_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.pmem_resp) resp_n++;
    end
    bus.pmem_read = 1'b0;
    repeat (12) @(negedge clk);
`ifndef PMEM_RESPONDER_JITTER_EN
    check("held_resps", LW'(resp_n), LW'(3));
    check("held_rd", LW'(rd_count), LW'(7));
`endif
    check("held_data", bus.pmem_rdata, L_DB);
    check("perr_sticky", LW'(proto_err), LW'(1));

    bus.pmem_address = 32'h0000_0040;
    bus.pmem_write   = 1'b1;
    bus.pmem_wdata   = L_X1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.pmem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    resp_n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.pmem_resp) resp_n++;
    end
    check("abort_resp", LW'(resp_n), '0);
    check("abort_perr", LW'(proto_err), '0);
    check("abort_rd", LW'(rd_count), '0);
    check("abort_wr", LW'(wr_count), '0);
    check("abort_rdata", bus.pmem_rdata, '0);
    do_req(32'h0000_0040, 1'b1, 1'b0, '0, lat);
    check("abort_keep", bus.pmem_rdata, L_DB);

    rst = 1'b0;
    bus.pmem_address = 32'h0000_0080;
    bus.pmem_read    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.pmem_resp && lat < 300);
    bus.pmem_read = 1'b0;
    repeat (2) @(negedge clk);
`ifndef PMEM_RESPONDER_JITTER_EN
    check("rel_lat", LW'(lat), LW'(5));
`endif
    check("rel_data", bus.pmem_rdata, L_55);
    check("rel_rd", LW'(rd_count), LW'(1));

`ifdef PMEM_RESPONDER_JITTER_EN
    begin
      logic [7:0] r;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      r = 8'hA5;
      for (int i = 0; i < 16; i++) begin
        do_req(32'h0000_0040, 1'b1, 1'b0, '0, lat);
        if (i == 0) check("jit_first", LW'(lat), LW'(6));
        check("jit_lat", LW'(lat), LW'(LAT + 1 + int'(r[1:0])));
        r = lfsr_step(r);
      end
      check("jit_rd", LW'(rd_count), LW'(16));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
